song_sequencer: RTL



---
 rtl/synth_pkg.sv | 29 ++
 rtl/song_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/synth_pkg.sv
// Shared widths, ROM entry layout and sequencer state encoding
// for the song playback path.
package synth_pkg;

  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int SONG_BITS  = 2;
  localparam int INDEX_BITS = 5;

  localparam int ROM_W  = NOTE_W + DUR_W;
  localparam int ADDR_W = SONG_BITS + INDEX_BITS;

  // ROM entry is {note, duration}
  localparam int NOTE_HI = ROM_W - 1;
  localparam int NOTE_LO = DUR_W;
  localparam int DUR_HI  = DUR_W - 1;
  localparam int DUR_LO  = 0;

  localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_LOAD,
    S_WAIT_DONE
  } seq_state_e;

endpackage

// File: rtl/song_sequencer.sv
// Walks a song in the external ROM and hands each
// {note, duration} to note_player with a load strobe.
module song_sequencer #(
  parameter int NOTE_W     = synth_pkg::NOTE_W,
  parameter int DUR_W      = synth_pkg::DUR_W,
  parameter int SONG_BITS  = synth_pkg::SONG_BITS,
  parameter int INDEX_BITS = synth_pkg::INDEX_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song_sel,
  input  logic                            new_song,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]         rom_data,
  output logic [NOTE_W-1:0]               note_to_load,
  output logic [DUR_W-1:0]                duration_to_load,
  output logic                            load_new_note,
  input  logic                            done_with_note,
  output logic                            song_done,
  output logic                            busy
);

  import synth_pkg::*;

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [SONG_BITS-1:0]  r_song;
  logic [SONG_BITS-1:0]  w_song_nxt;
  logic [INDEX_BITS-1:0] r_idx;
  logic [INDEX_BITS-1:0] w_idx_nxt;
  logic [NOTE_W-1:0]     r_note;
  logic [NOTE_W-1:0]     w_note_nxt;
  logic [DUR_W-1:0]      r_dur;
  logic [DUR_W-1:0]      w_dur_nxt;
  logic                  r_load;
  logic                  w_load_nxt;
  logic                  r_sdone;
  logic                  w_sdone_nxt;

  logic [NOTE_W-1:0] w_rom_note;
  logic [DUR_W-1:0]  w_rom_dur;
  logic              w_last;
  logic              w_done_ok;
  logic              w_restart;

  assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];
  assign w_last     = &r_idx;
  // a done seen alongside our own strobe belongs to the old note
  assign w_done_ok  = done_with_note & ~r_load;
  assign w_restart  = new_song & (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_song_nxt  = r_song;
    w_idx_nxt   = r_idx;
    w_note_nxt  = r_note;
    w_dur_nxt   = r_dur;
    w_load_nxt  = 1'b0;
    w_sdone_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_song_nxt = song_sel;
        if (play) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (play) begin
          w_state_nxt = S_WAIT_ROM;
        end
      end
      S_WAIT_ROM: begin
        w_note_nxt = w_rom_note;
        w_dur_nxt  = w_rom_dur;
        if (w_rom_dur == END_MARKER_DUR) begin
          w_sdone_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load_nxt  = 1'b1;
        w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done_ok) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_sdone_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // restart overrides whatever the state above decided
    if (w_restart) begin
      w_song_nxt  = song_sel;
      w_idx_nxt   = '0;
      w_note_nxt  = r_note;
      w_dur_nxt   = r_dur;
      w_load_nxt  = 1'b0;
      w_sdone_nxt = 1'b0;
      w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_song  <= '0;
      r_idx   <= '0;
      r_note  <= '0;
      r_dur   <= '0;
      r_load  <= 1'b0;
      r_sdone <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_song  <= w_song_nxt;
      r_idx   <= w_idx_nxt;
      r_note  <= w_note_nxt;
      r_dur   <= w_dur_nxt;
      r_load  <= w_load_nxt;
      r_sdone <= w_sdone_nxt;
    end
  end

  assign rom_addr         = {r_song, r_idx};
  assign note_to_load     = r_note;
  assign duration_to_load = r_dur;
  assign load_new_note    = r_load;
  assign song_done        = r_sdone;
  assign busy             = (r_state != S_IDLE);

endmodule
